// File: rtl/freduce_min.sv
`default_nettype none
// ============================================================================
// Module   : freduce_min
// Purpose  : Streaming minimum reduction over FloPoCo-format packets.
// Revision : 1.0
// ============================================================================
module freduce_min #(
    parameter int WE   = 8,
    parameter int WF   = 23,
    parameter int IDXW = 16,
    localparam int WIDTH = WE + WF + 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_index,
    output logic             out_nan,
    output logic             out_ovf
);

    localparam logic [IDXW-1:0] c_CNT_MAX = {IDXW{1'b1}};

    typedef enum logic [1:0] {
        S_FIRST = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_in_nan;
    logic               w_best_nan;
    logic               w_replace;
    logic [WIDTH-1:0]   r_best;
    logic [IDXW-1:0]    r_best_idx;
    logic [IDXW-1:0]    r_cnt;
    logic               r_sat;
    logic               r_nan;
    logic               r_ovf;

    // Strict a < b for two ordered (non-NaN) operands. Zeros collapse to
    // magnitude 0 so every zero encoding compares equal.
    function automatic logic f_less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic             a_zero;
        logic             b_zero;
        logic             a_neg;
        logic             b_neg;
        logic [WIDTH-2:0] a_mag;
        logic [WIDTH-2:0] b_mag;
        a_zero = (a[WIDTH-1 -: 2] == 2'b00);
        b_zero = (b[WIDTH-1 -: 2] == 2'b00);
        a_neg  = a[WE+WF] & ~a_zero;
        b_neg  = b[WE+WF] & ~b_zero;
        a_mag  = a_zero ? '0 : {a[WIDTH-1 -: 2], a[WE+WF-1:0]};
        b_mag  = b_zero ? '0 : {b[WIDTH-1 -: 2], b[WE+WF-1:0]};
        if (a_neg != b_neg) begin
            return a_neg;
        end else if (a_neg) begin
            return a_mag > b_mag;
        end else begin
            return a_mag < b_mag;
        end
    endfunction

    assign w_accept   = in_valid & w_in_ready;
    assign w_in_nan   = (in_data[WIDTH-1 -: 2] == 2'b11);
    assign w_best_nan = (r_best[WIDTH-1 -: 2] == 2'b11);
    assign w_replace  = ~w_in_nan & (w_best_nan | f_less(in_data, r_best));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FIRST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_FIRST: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_FIRST;
                end
            end
            default: begin
                w_state_nxt = S_FIRST;
            end
        endcase
    end

    // r_sat marks that index 2^IDXW-1 has been handed out; any later
    // element means the packet is longer than the index space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best     <= '0;
            r_best_idx <= '0;
            r_cnt      <= '0;
            r_sat      <= 1'b0;
            r_nan      <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            if (r_state == S_FIRST) begin
                r_best     <= in_data;
                r_best_idx <= '0;
                r_cnt      <= IDXW'(1);
                r_sat      <= 1'b0;
                r_nan      <= w_in_nan;
                r_ovf      <= 1'b0;
            end else begin
                if (w_replace) begin
                    r_best     <= in_data;
                    r_best_idx <= r_cnt;
                end
                if (r_cnt == c_CNT_MAX) begin
                    r_sat <= 1'b1;
                    if (r_sat) begin
                        r_ovf <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + IDXW'(1);
                end
                r_nan <= r_nan | w_in_nan;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_best;
    assign out_index = r_best_idx;
    assign out_nan   = r_nan;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_freduce_min.sv
`default_nettype none
// ============================================================================
// Module   : tb_freduce_min
// Purpose  : Self-checking bench for freduce_min (WE=8, WF=23, IDXW=2).
// Revision : 1.0
// ============================================================================
module tb_freduce_min;

    localparam int WE   = 8;
    localparam int WF   = 23;
    localparam int IDXW = 2;
    localparam int W    = WE + WF + 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_data;
    logic            in_last;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [IDXW-1:0] out_index;
    logic            out_nan;
    logic            out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] pkt[$];

    freduce_min #(.WE(WE), .WF(WF), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_nan   (out_nan),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [1:0] e, input logic s,
                                        input logic [7:0] x, input logic [22:0] f);
        return {e, s, x, f};
    endfunction

    // Reference ordering: a signed integer rank, zero for every zero encoding.
    function automatic longint rank(input logic [W-1:0] d);
        longint mag;
        if (d[W-1 -: 2] == 2'b00) return 0;
        mag = longint'({d[W-1 -: 2], d[WE+WF-1:0]});
        return d[WE+WF] ? -mag : mag;
    endfunction

    function automatic logic is_nan(input logic [W-1:0] d);
        return d[W-1 -: 2] == 2'b11;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("push_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the in_last accept: result must be up next cycle.
    task automatic check_result(input string tag, input logic [W-1:0] ed,
                                input int eidx, input logic enan, input logic eovf);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  64'(ed));
        chk({tag, "_index"}, 64'(out_index), 64'(eidx));
        chk({tag, "_nan"},   64'(out_nan),   64'(enan));
        chk({tag, "_ovf"},   64'(out_ovf),   64'(eovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_release"}, {62'd0, out_valid, in_ready}, 64'b01);
    endtask

    task automatic send_pkt(input logic gaps);
        for (int i = 0; i < pkt.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
            push(pkt[i], i == pkt.size() - 1);
        end
    endtask

    task automatic model(output logic [W-1:0] ed, output int eidx,
                         output logic enan, output logic eovf);
        int best;
        best = -1;
        enan = 1'b0;
        foreach (pkt[i]) begin
            if (is_nan(pkt[i])) enan = 1'b1;
            else if (best < 0 || rank(pkt[i]) < rank(pkt[best])) best = i;
        end
        if (best < 0) best = 0;
        ed   = pkt[best];
        eidx = (best > (1 << IDXW) - 1) ? (1 << IDXW) - 1 : best;
        eovf = pkt.size() > (1 << IDXW);
    endtask

    function automatic logic [W-1:0] rand_word();
        int r;
        logic [1:0] e;
        r = $urandom_range(0, 9);
        e = (r == 0) ? 2'b00 : (r <= 6) ? 2'b01 : (r == 7) ? 2'b10 : 2'b11;
        return mk(e, 1'($urandom_range(0, 1)), 8'($urandom_range(8'h7E, 8'h81)),
                  23'($urandom_range(0, 3)) << 20);
    endfunction

    logic [W-1:0] F1, FM1, F2, F3, F4, F5, F6, F7, QNAN, PZ, NZ, NINF;
    logic [W-1:0] e_d;
    int           e_i;
    logic         e_n, e_o;

    initial begin
        F1   = mk(2'b01, 1'b0, 8'h7F, 23'h0);
        FM1  = mk(2'b01, 1'b1, 8'h7F, 23'h0);
        F2   = mk(2'b01, 1'b0, 8'h80, 23'h0);
        F3   = mk(2'b01, 1'b0, 8'h80, 23'h400000);
        F4   = mk(2'b01, 1'b0, 8'h81, 23'h0);
        F5   = mk(2'b01, 1'b0, 8'h81, 23'h200000);
        F6   = mk(2'b01, 1'b0, 8'h81, 23'h400000);
        F7   = mk(2'b01, 1'b0, 8'h81, 23'h600000);
        QNAN = mk(2'b11, 1'b0, 8'h00, 23'h0);
        PZ   = mk(2'b00, 1'b0, 8'h00, 23'h0);
        NZ   = mk(2'b00, 1'b1, 8'h00, 23'h0);
        NINF = mk(2'b10, 1'b1, 8'h00, 23'h0);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_outputs",   {out_data, out_index, out_nan, out_ovf}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pkt = '{F2, FM1, F1};
        send_pkt(1'b0);
        check_result("basic", FM1, 1, 1'b0, 1'b0);

        pkt = '{QNAN, F2, QNAN, F1};
        send_pkt(1'b0);
        check_result("nan_mix", F1, 3, 1'b1, 1'b0);

        pkt = '{PZ, NZ, NINF};
        send_pkt(1'b0);
        check_result("neg_inf", NINF, 2, 1'b0, 1'b0);

        pkt = '{PZ, NZ};
        send_pkt(1'b0);
        check_result("zero_tie", PZ, 0, 1'b0, 1'b0);

        pkt = '{QNAN, mk(2'b11, 1'b1, 8'h12, 23'h5)};
        send_pkt(1'b0);
        check_result("all_nan", QNAN, 0, 1'b1, 1'b0);

        pkt = '{F3};
        send_pkt(1'b0);
        check_result("single", F3, 0, 1'b0, 1'b0);

        // Back-pressure: hold result while an input beat waits.
        pkt = '{F2, F3};
        send_pkt(1'b0);
        in_valid = 1'b1; in_data = F7; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_state", {out_valid, out_data, out_index, out_nan, out_ovf},
                {1'b1, F2, 2'd0, 1'b0, 1'b0});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("hold_release", {62'd0, out_valid, in_ready}, 64'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
        check_result("after_hold", F7, 0, 1'b0, 1'b0);

        pkt = '{F6, F5, F4, F3, F2, F1};
        send_pkt(1'b0);
        check_result("overflow", F1, 3, 1'b0, 1'b1);

        // Reset mid-packet discards the partial result.
        push(F2, 1'b0);
        push(F3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", {out_valid, in_ready, out_data, out_index, out_nan, out_ovf},
            {1'b0, 1'b1, 38'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_valid", 64'(out_valid), 64'd0);
        pkt = '{F5};
        send_pkt(1'b0);
        check_result("post_rst", F5, 0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int len;
            len = $urandom_range(1, 7);
            pkt.delete();
            for (int k = 0; k < len; k++) pkt.push_back(rand_word());
            send_pkt(1'b1);
            model(e_d, e_i, e_n, e_o);
            check_result($sformatf("rand%0d", n), e_d, e_i, e_n, e_o);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
